// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states, opcode width.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOTA = 4'd0;
    localparam logic [OP_W-1:0] OP_NOTB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 4'd5;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd6;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd9;
    localparam logic [OP_W-1:0] OP_SAR  = 4'd10;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops 0-7 with their C/N/Z/V flags.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v
);

    logic             sub;
    logic [WIDTH-1:0] bo;
    logic [WIDTH:0]   sum;

    // SUB is a + ~b + 1, so the adder is shared with ADD
    always_comb begin
        sub = (op == OP_SUB);
        bo  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bo} + (WIDTH+1)'(sub);
        result = '0;
        c = 1'b0;
        v = 1'b0;
        unique case (1'b1)
            op == OP_NOTA: result = ~a;
            op == OP_NOTB: result = ~b;
            op == OP_AND:  result = a & b;
            op == OP_OR:   result = a | b;
            op == OP_XOR:  result = a ^ b;
            op == OP_XNOR: result = ~(a ^ b);
            (op == OP_ADD) || sub: begin
                result = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] ^ bo[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
            end
            default: ;
        endcase
        n = result[WIDTH-1];
        z = (result == '0);
    end

endmodule

// File: rtl/alu_seq_n.sv
// N-bit sequential ALU: 1-cycle logic/arith, iterative shifts, optional
// shift-add multiply built only when ALU_MUL_EN is defined.
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    localparam int CNT_W = SH_W + 1;
`else
    localparam int CNT_W = SH_W;
`endif

    state_t             state, state_nx;
    logic [OP_W-1:0]    op_q;
    logic [WIDTH-1:0]   sh, sh_nx;
    logic               sh_out;
    logic [CNT_W-1:0]   cnt;
    logic [SH_W-1:0]    shamt;
    logic               accept, is_shift, is_mul, multi, last;
    logic [WIDTH-1:0]   core_r;
    logic               core_c, core_n, core_z, core_v;
    logic               wr, use_core, w_c, w_n, w_z, w_v, w_err;
    logic [WIDTH-1:0]   w_res;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_nx;
    logic [WIDTH:0]     psum;
`endif

    assign shamt    = b[SH_W-1:0];
    assign accept   = in_valid & in_ready;
    assign is_shift = (op == OP_SHL) | (op == OP_SHR) | (op == OP_SAR);
`ifdef ALU_MUL_EN
    assign is_mul   = (op == OP_MUL);
`else
    assign is_mul   = 1'b0;
`endif
    assign multi = accept & ((is_shift & (shamt != '0)) | is_mul);
    assign last  = (state == S_BUSY) & (cnt == CNT_W'(1));

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (core_r),
        .c      (core_c),
        .n      (core_n),
        .z      (core_z),
        .v      (core_v)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) state_nx = multi ? S_BUSY : S_DONE;
                else        state_nx = S_IDLE;
            end
            S_BUSY:  if (last) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != S_BUSY);
        out_valid = (state == S_DONE);
    end

    always_comb begin
        sh_nx  = sh;
        sh_out = 1'b0;
        unique case (1'b1)
            op_q == OP_SHL: begin
                sh_nx  = {sh[WIDTH-2:0], 1'b0};
                sh_out = sh[WIDTH-1];
            end
            op_q == OP_SHR: begin
                sh_nx  = {1'b0, sh[WIDTH-1:1]};
                sh_out = sh[0];
            end
            op_q == OP_SAR: begin
                sh_nx  = {sh[WIDTH-1], sh[WIDTH-1:1]};
                sh_out = sh[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    // {high, multiplier} shifts right; high half accumulates a partial product
    assign psum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_nx = {psum, prod[WIDTH-1:1]};
`endif

    always_comb begin
        wr = 1'b0;
        use_core = 1'b0;
        w_res = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        w_err = 1'b0;
        if (accept && !multi) begin
            wr = 1'b1;
            unique case (1'b1)
                !op[3]: begin
                    use_core = 1'b1;
                    w_res = core_r;
                    w_c = core_c;
                    w_v = core_v;
                end
                is_shift: w_res = a;
                default:  w_err = 1'b1;
            endcase
        end else if (last) begin
            wr = 1'b1;
`ifdef ALU_MUL_EN
            if (op_q == OP_MUL) begin
                w_res = prod_nx[WIDTH-1:0];
                w_c = |prod_nx[2*WIDTH-1:WIDTH];
                w_v = w_c;
            end else begin
                w_res = sh_nx;
                w_c = sh_out;
            end
`else
            w_res = sh_nx;
            w_c = sh_out;
`endif
        end
        w_n = use_core ? core_n : w_res[WIDTH-1];
        w_z = use_core ? core_z : (w_res == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
            sh   <= '0;
            cnt  <= '0;
`ifdef ALU_MUL_EN
            mcand <= '0;
            prod  <= '0;
`endif
        end else if (multi) begin
            op_q <= op;
            sh   <= a;
            cnt  <= is_mul ? CNT_W'(WIDTH) : CNT_W'(shamt);
`ifdef ALU_MUL_EN
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
`endif
        end else if (state == S_BUSY) begin
            sh  <= sh_nx;
            cnt <= cnt - CNT_W'(1);
`ifdef ALU_MUL_EN
            prod <= prod_nx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            c   <= 1'b0;
            n   <= 1'b0;
            z   <= 1'b0;
            v   <= 1'b0;
            err <= 1'b0;
        end else if (wr) begin
            result <= w_res;
            c   <= w_c;
            n   <= w_n;
            z   <= w_z;
            v   <= w_v;
            err <= w_err;
        end
    end

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n (WIDTH = 32), directed plus random ops.
module tb_alu_seq_n;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  op = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        c, n, z, v, err;

    int n_asrt = 0;
    int n_fail = 0;

    alu_seq_n #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .result    (result),
        .c         (c),
        .n         (n),
        .z         (z),
        .v         (v),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from plain arithmetic on the operands
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop,
                         output logic [31:0] r, output logic ec, output logic ev,
                         output logic ee, output int lat);
        int s;
        logic [32:0] w;
        logic [63:0] p;
        s = int'(mb[4:0]);
        r = '0; ec = 1'b0; ev = 1'b0; ee = 1'b0; lat = 1;
        p = '0;
        case (mop)
            4'd0: r = ~ma;
            4'd1: r = ~mb;
            4'd2: r = ma & mb;
            4'd3: r = ma | mb;
            4'd4: r = ma ^ mb;
            4'd5: r = ~(ma ^ mb);
            4'd6: begin
                w = {1'b0, ma} + {1'b0, mb};
                r = w[31:0];
                ec = w[32];
                ev = (ma[31] == mb[31]) && (r[31] != ma[31]);
            end
            4'd7: begin
                r = ma - mb;
                ec = (ma >= mb);
                ev = (ma[31] != mb[31]) && (r[31] != ma[31]);
            end
            4'd8: begin
                r = ma << s;
                ec = (s != 0) ? ma[32-s] : 1'b0;
                lat = s + 1;
            end
            4'd9: begin
                r = ma >> s;
                ec = (s != 0) ? ma[s-1] : 1'b0;
                lat = s + 1;
            end
            4'd10: begin
                r = $signed(ma) >>> s;
                ec = (s != 0) ? ma[s-1] : 1'b0;
                lat = s + 1;
            end
`ifdef ALU_MUL_EN
            4'd11: begin
                p = {32'b0, ma} * {32'b0, mb};
                r = p[31:0];
                ec = |p[63:32];
                ev = ec;
                lat = 33;
            end
`endif
            default: ee = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [3:0] iop);
        logic [31:0] er;
        logic ec, ev, ee;
        int el, lat, busy_low;
        model(ia, ib, iop, er, ec, ev, ee, el);
        @(negedge clk);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        chk({tag, " in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_low = 0;
        while (!out_valid && lat < 80) begin
            if (!in_ready) busy_low++;
            a = $urandom; b = $urandom; op = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, el);
        chk({tag, " busy"}, busy_low, el - 1);
        chk({tag, " result"}, result, er);
        chk({tag, " cnzv"}, {c, n, z, v}, {ec, er[31], er == 32'h0, ev});
        chk({tag, " err"}, err, ee);
        @(negedge clk);
        chk({tag, " pulse"}, out_valid, 0);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset outs", {result, c, n, z, v, err}, 38'h0);
        reset = 1'b0;
        chk("reset in_ready", in_ready, 1);

        run_op("add ovf", 32'h7FFF_FFFF, 32'h1, OP_ADD);
        chk("add const", {result, c, n, z, v}, {32'h8000_0000, 4'b0101});
        run_op("sub eq", 32'h5, 32'h5, OP_SUB);
        chk("sub eq const", {result, c, n, z, v}, {32'h0, 4'b1010});
        run_op("sub borrow", 32'h0, 32'h1, OP_SUB);
        chk("sub borrow const", {result, c, n}, {32'hFFFF_FFFF, 2'b01});
        run_op("sar4", 32'h8000_0000, 32'h4, OP_SAR);
        chk("sar4 const", {result, c, n}, {32'hF800_0000, 2'b01});
        run_op("shl1", 32'h8000_0001, 32'h1, OP_SHL);
        chk("shl1 const", {result, c}, {32'h2, 1'b1});

        @(negedge clk);
        a = 32'h1234_5678; b = 32'd20; op = OP_SHL; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort outs", {result, c, n, z, v, err}, 38'h0);
        chk("abort in_ready", in_ready, 1);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort no pulse", pulses, 0);

        run_op("mul", 32'h0001_0000, 32'h0001_0000, OP_MUL);
        run_op("shr0", 32'hA5A5_0F0F, 32'h20, OP_SHR);
        run_op("illegal", 32'hFFFF_FFFF, 32'h3, 4'd13);
        run_op("xnor", 32'h1234_5678, 32'h1234_5678, OP_XNOR);

        @(negedge clk);
        a = 32'hF0F0_00FF; b = 32'hFF00_FF00; op = OP_AND; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = OP_OR;
        chk("b2b and valid", out_valid, 1);
        chk("b2b and result", result, 32'hF000_0000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b or valid", out_valid, 1);
        chk("b2b or result", result, 32'hFFF0_FFFF);
        @(negedge clk);
        chk("b2b end", out_valid, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) rb[4:0] = 5'd0;
            run_op($sformatf("rand%0d op%0d", i, rop), ra, rb, rop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
